// File: rtl/range_finder_pkg.sv
// Shared definitions for the range finder trigger output port:
// register map, CONTROL/STATUS bit positions and trigger FSM states.
package range_finder_pkg;

    localparam logic [1:0] ADDR_DATA        = 2'd0;
    localparam logic [1:0] ADDR_PULSE_WIDTH = 2'd1;
    localparam logic [1:0] ADDR_CONTROL     = 2'd2;
    localparam logic [1:0] ADDR_STATUS      = 2'd3;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_AUTO_BIT  = 1;

    localparam int STAT_BUSY_BIT  = 0;
    localparam int STAT_DONE_BIT  = 1;
    localparam int STAT_COUNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PULSE   = 2'd1,
        HOLDOFF = 2'd2
    } trig_state_e;

endpackage

// File: rtl/range_finder_trigger_fsm.sv
// Trigger pulse sequencer: programmable-width high pulse, fixed low holdoff,
// optional auto-repeat. Emits a one-cycle done_pulse_o at the end of each holdoff.
module range_finder_trigger_fsm
    import range_finder_pkg::*;
#(
    parameter int unsigned WIDTH_BITS     = 16,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned HOLDOFF_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic                  auto_i,
    input  logic [WIDTH_BITS-1:0] width_i,
    output logic                  trigger_o,
    output logic                  busy_o,
    output logic                  done_pulse_o
);

    localparam logic [HOLDOFF_BITS-1:0] HOLD_LOAD = HOLDOFF_BITS'(HOLDOFF_CYCLES - 1);

    trig_state_e             state_q, state_d;
    logic [WIDTH_BITS-1:0]   pulse_cnt_q, pulse_cnt_d;
    logic [HOLDOFF_BITS-1:0] hold_cnt_q, hold_cnt_d;
    logic                    trigger_q;
    logic [WIDTH_BITS-1:0]   width_load;

    // A zero width is promoted to a one-cycle pulse.
    assign width_load = (width_i == '0) ? '0 : width_i - WIDTH_BITS'(1);

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        pulse_cnt_d  = pulse_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        done_pulse_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = PULSE;
                    pulse_cnt_d = width_load;
                end
            end
            PULSE: begin
                if (pulse_cnt_q == '0) begin
                    state_d    = HOLDOFF;
                    hold_cnt_d = HOLD_LOAD;
                end else begin
                    pulse_cnt_d = pulse_cnt_q - WIDTH_BITS'(1);
                end
            end
            HOLDOFF: begin
                if (hold_cnt_q == '0) begin
                    done_pulse_o = 1'b1;
                    if (auto_i) begin
                        state_d     = PULSE;
                        pulse_cnt_d = width_load;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    hold_cnt_d = hold_cnt_q - HOLDOFF_BITS'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            pulse_cnt_q <= '0;
            hold_cnt_q  <= '0;
            trigger_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pulse_cnt_q <= pulse_cnt_d;
            hold_cnt_q  <= hold_cnt_d;
            trigger_q   <= (state_d == PULSE);
        end
    end

    assign trigger_o = trigger_q;
    assign busy_o    = (state_q != IDLE);

endmodule

// File: rtl/range_finder_trigger_out.sv
// Avalon-MM output port for the range finder: CPU data word on out_port plus
// control/status registers for the ultrasonic trigger sequencer.
module range_finder_trigger_out
    import range_finder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 9,
    parameter int unsigned WIDTH_BITS     = 16,
    parameter int unsigned PULSE_DEFAULT  = 500,
    parameter int unsigned HOLDOFF_CYCLES = 3000000,
    parameter int unsigned HOLDOFF_BITS   = 22
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic                  trigger_out
);

    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [WIDTH_BITS-1:0] width_q, width_d;
    logic                  auto_q, auto_d;
    logic                  done_q, done_d;
    logic [7:0]            count_q, count_d;
    logic [31:0]           readdata_q, readdata_d;

    logic wr, start, busy, done_pulse;
    logic unused_wdata;

    assign wr    = chipselect & ~write_n;
    assign start = wr && (address == ADDR_CONTROL) && writedata[CTRL_START_BIT];
    assign unused_wdata = ^writedata;

    range_finder_trigger_fsm #(
        .WIDTH_BITS     (WIDTH_BITS),
        .HOLDOFF_CYCLES (HOLDOFF_CYCLES),
        .HOLDOFF_BITS   (HOLDOFF_BITS)
    ) u_fsm (
        .clk          (clk),
        .reset        (reset),
        .start_i      (start),
        .auto_i       (auto_q),
        .width_i      (width_q),
        .trigger_o    (trigger_out),
        .busy_o       (busy),
        .done_pulse_o (done_pulse)
    );

    always_comb begin
        data_d  = data_q;
        width_d = width_q;
        auto_d  = auto_q;
        done_d  = done_q;
        count_d = count_q;
        if (wr) begin
            case (address)
                ADDR_DATA:        data_d  = writedata[DATA_WIDTH-1:0];
                ADDR_PULSE_WIDTH: width_d = writedata[WIDTH_BITS-1:0];
                ADDR_CONTROL:     auto_d  = writedata[CTRL_AUTO_BIT];
                ADDR_STATUS:      if (writedata[STAT_DONE_BIT]) done_d = 1'b0;
                default: ;
            endcase
        end
        // Applied after the clear so a coincident completion keeps DONE set.
        if (done_pulse) begin
            done_d  = 1'b1;
            count_d = count_q + 8'd1;
        end
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:        readdata_d[DATA_WIDTH-1:0] = data_q;
            ADDR_PULSE_WIDTH: readdata_d[WIDTH_BITS-1:0] = width_q;
            ADDR_CONTROL: begin
                readdata_d[CTRL_START_BIT] = busy;
                readdata_d[CTRL_AUTO_BIT]  = auto_q;
            end
            ADDR_STATUS: begin
                readdata_d[STAT_BUSY_BIT]               = busy;
                readdata_d[STAT_DONE_BIT]               = done_q;
                readdata_d[STAT_COUNT_LSB +: 8]         = count_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= '0;
            width_q    <= WIDTH_BITS'(PULSE_DEFAULT);
            auto_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            width_q    <= width_d;
            auto_q     <= auto_d;
            done_q     <= done_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q;

endmodule
